wb_slave_regfile: RTL and testbench

- Parametrised Wishbone classic slave: a bank of NUM_REGS registers, each DATA_WIDTH bits wide, with byte-lane write enables.
- Adds programmable wait states, per-register read-only protection, error termination for out-of-range addresses, and abort on strobe/cycle drop.
- Sits on the shared Wishbone bus as a general control/status block.
- Register contents are also exported in parallel to downstream logic.

---
 rtl/wb_slave_regfile_if.sv | 26 ++
 rtl/wb_slave_regfile.sv | 145 ++++++++++++++
 tb/tb_wb_slave_regfile.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_slave_regfile_if.sv
// Wishbone classic bus bundle for the register-file slave.
// The master modport drives the request side; the slave modport drives the termination side.
interface wb_slave_regfile_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] sel_i;
  logic                    stb_i;
  logic                    cyc_i;
  logic                    ack_o;
  logic                    err_o;

  modport master (
    output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i,
    output dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_slave_regfile.sv
// Wishbone classic register-file slave with byte lanes, programmable wait states,
// read-only protection, error termination on bad addresses and abort on strobe/cycle drop.
module wb_slave_regfile #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_REGS    = 4,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  wb_slave_regfile_if.slave              bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [3:0]              cnt;
  logic [3:0]              cnt_next;
  logic                    req;
  logic                    accept;
  logic                    commit;

  logic [ADDR_WIDTH-1:0]   lat_adr;
  logic [DATA_WIDTH-1:0]   lat_dat;
  logic                    lat_we;
  logic [SEL_WIDTH-1:0]    lat_sel;

  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    ack_q;
  logic                    err_q;
  logic                    hit;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign req = bus.cyc_i & bus.stb_i;

  // TERM is the single cycle whose closing edge commits the transfer and raises ack/err.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = TERM;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 4'd1;
          if (cnt == 4'd1) state_next = TERM;
        end
      end
      TERM: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Address decode on the latched address; a miss means the transfer ends in err.
  always_comb begin
    hit     = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (lat_adr == ADDR_WIDTH'(i)) begin
        hit     = 1'b1;
        rd_data = regs[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      lat_adr <= '0;
      lat_dat <= '0;
      lat_we  <= 1'b0;
      lat_sel <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (accept) begin
        lat_adr <= bus.adr_i;
        lat_dat <= bus.dat_i;
        lat_we  <= bus.we_i;
        lat_sel <= bus.sel_i;
      end
      if (commit) begin
        if (hit) begin
          ack_q <= 1'b1;
          if (!lat_we) dat_q <= rd_data;
        end else begin
          err_q <= 1'b1;
          dat_q <= '0;
        end
      end
      // Read-only registers still acknowledge writes but never change.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && lat_we && (lat_adr == ADDR_WIDTH'(i)) && !RO_MASK[i]) begin
          for (int b = 0; b < SEL_WIDTH; b++) begin
            if (lat_sel[b]) regs[i][8*b +: 8] <= lat_dat[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.dat_o = dat_q;
  assign bus.ack_o = ack_q & req;
  assign bus.err_o = err_q & req;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end
endmodule

// File: tb/tb_wb_slave_regfile.sv
// Bench for wb_slave_regfile: two differently parameterised slaves driven by directed and
// random transfers, checked every cycle against a transaction-level model of the register bank.
module tb_wb_slave_regfile;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_slave_regfile_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) bus8 ();
  wb_slave_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus32 ();
  logic [31:0]  regs8;
  logic [159:0] regs32;

  wb_slave_regfile #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4), .WAIT_STATES(0),
    .RO_MASK(4'b0001), .RESET_VALUE(8'hA5)
  ) u8 (.clk_i(clk), .rst_i(rst), .bus(bus8), .regs_o(regs8));

  wb_slave_regfile #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(5), .WAIT_STATES(3),
    .RO_MASK(5'b00100), .RESET_VALUE(32'h11223344)
  ) u32 (.clk_i(clk), .rst_i(rst), .bus(bus32), .regs_o(regs32));

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int pin_id   = 0;

  logic [31:0] exp_regs [2][5];
  logic [31:0] exp_dat  [2];
  logic        exp_ack  [2];
  logic        exp_err  [2];

  function automatic int wait_of(input int d);   return (d == 0) ? 0 : 3; endfunction
  function automatic int nregs_of(input int d);  return (d == 0) ? 4 : 5; endfunction
  function automatic int nbytes_of(input int d); return (d == 0) ? 1 : 4; endfunction
  function automatic logic [31:0] ro_of(input int d); return (d == 0) ? 32'h1 : 32'h4; endfunction
  function automatic logic [31:0] rv_of(input int d); return (d == 0) ? 32'hA5 : 32'h11223344; endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) exp_regs[d][i] = (i < nregs_of(d)) ? rv_of(d) : 32'h0;
      exp_dat[d] = '0;
      exp_ack[d] = 1'b0;
      exp_err[d] = 1'b0;
    end
  endtask

  // Effect of one completed transfer on the register bank and read data.
  task automatic commit_model(input int d, input logic [7:0] adr, input logic [31:0] dat,
                              input logic we, input logic [3:0] sel);
    int a = int'(adr);
    if (a < nregs_of(d)) begin
      if (we) begin
        if (ro_of(d)[a] == 1'b0)
          for (int b = 0; b < nbytes_of(d); b++)
            if (sel[b]) exp_regs[d][a][8*b +: 8] = dat[8*b +: 8];
      end else begin
        exp_dat[d] = exp_regs[d][a];
      end
    end else begin
      exp_dat[d] = '0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    pin_id = 0;
  endtask

  task automatic drive(input int d, input logic c, input logic s, input logic we,
                       input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      bus8.cyc_i = c;  bus8.stb_i = s;  bus8.we_i = we;
      bus8.adr_i = adr; bus8.dat_i = dat[7:0]; bus8.sel_i = sel[0:0];
    end else begin
      bus32.cyc_i = c; bus32.stb_i = s; bus32.we_i = we;
      bus32.adr_i = adr; bus32.dat_i = dat; bus32.sel_i = sel;
    end
  endtask

  // One transfer: request held for 2+WAIT_STATES edges; drop_at (1..WAIT_STATES+1) lowers
  // stb or cyc before that edge; hold keeps the request up so the next call is back-to-back.
  task automatic apply_stimulus(input int d, input logic [7:0] adr, input logic [31:0] dat,
                                input logic we, input logic [3:0] sel, input int drop_at,
                                input bit hold, input int pin);
    int  w       = wait_of(d);
    bit  valid   = int'(adr) < nregs_of(d);
    bit  dropped = 1'b0;
    for (int j = 0; j <= w + 1; j++) begin
      step();
      exp_ack[d] = 1'b0;
      exp_err[d] = 1'b0;
      if (j == drop_at) begin
        dropped = 1'b1;
        if ($urandom_range(1) == 0) drive(d, 1'b0, 1'b1, we, adr, dat, sel);
        else                        drive(d, 1'b1, 1'b0, we, adr, dat, sel);
      end else if (!dropped) begin
        drive(d, 1'b1, 1'b1, we, adr, dat, sel);
      end
      if (dropped && j <= w) return;
      if (j == w + 1) begin
        commit_model(d, adr, dat, we, sel);
        exp_ack[d] = valid && !dropped;
        exp_err[d] = !valid && !dropped;
        pin_id     = pin;
      end
    end
    if (!hold) begin
      step();
      drive(d, 1'b0, 1'b0, we, adr, dat, sel);
      exp_ack[d] = 1'b0;
      exp_err[d] = 1'b0;
    end
  endtask

  // Single compare process: every cycle, shortly after the rising edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check_output("ack8",  32'(bus8.ack_o),  32'(exp_ack[0]));
      check_output("err8",  32'(bus8.err_o),  32'(exp_err[0]));
      check_output("dat8",  32'(bus8.dat_o),  exp_dat[0]);
      check_output("ack32", 32'(bus32.ack_o), 32'(exp_ack[1]));
      check_output("err32", 32'(bus32.err_o), 32'(exp_err[1]));
      check_output("dat32", bus32.dat_o,      exp_dat[1]);
      check_output("excl8",  32'(bus8.ack_o & bus8.err_o),   32'h0);
      check_output("excl32", 32'(bus32.ack_o & bus32.err_o), 32'h0);
      for (int i = 0; i < 4; i++)
        check_output($sformatf("reg8[%0d]", i), 32'(regs8[i*8 +: 8]), exp_regs[0][i]);
      for (int i = 0; i < 5; i++)
        check_output($sformatf("reg32[%0d]", i), regs32[i*32 +: 32], exp_regs[1][i]);
      case (pin_id)
        1, 7: begin
          check_output("pin_reset_regs8", regs8, 32'hA5A5A5A5);
          check_output("pin_reset_ack32", 32'(bus32.ack_o), 32'h0);
          for (int i = 0; i < 5; i++)
            check_output("pin_reset_regs32", regs32[i*32 +: 32], 32'h11223344);
        end
        2: begin
          check_output("pin_read_dat8", 32'(bus8.dat_o), 32'h3C);
          check_output("pin_read_reg8", 32'(regs8[23:16]), 32'h3C);
          check_output("pin_read_ack8", 32'(bus8.ack_o), 32'h1);
        end
        3: begin
          check_output("pin_bytelane", regs32[63:32], 32'h11BB33DD);
          check_output("pin_bytelane_ack", 32'(bus32.ack_o), 32'h1);
        end
        4: begin
          check_output("pin_err_err8", 32'(bus8.err_o), 32'h1);
          check_output("pin_err_ack8", 32'(bus8.ack_o), 32'h0);
          check_output("pin_err_dat8", 32'(bus8.dat_o), 32'h0);
        end
        5: begin
          check_output("pin_ro_ack8", 32'(bus8.ack_o), 32'h1);
          check_output("pin_ro_reg8", 32'(regs8[7:0]), 32'hA5);
        end
        6: begin
          check_output("pin_wait_ack32", 32'(bus32.ack_o), 32'h1);
          check_output("pin_wait_dat32", bus32.dat_o, 32'h11BB33DD);
        end
        8: begin
          check_output("pin_termdrop_ack32", 32'(bus32.ack_o), 32'h0);
          check_output("pin_termdrop_reg32", regs32[127:96], 32'hCAFEF00D);
        end
        default: ;
      endcase
    end
  end

  initial begin
    logic [7:0]  adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          drop;
    bit          hold;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    reset_model();
    step();
    step();
    chk_en = 1'b1;
    pin_id = 1;
    step();
    rst = 1'b0;

    // 8-bit slave, no wait states, register 0 read-only.
    apply_stimulus(0, 8'd2, 32'h3C, 1'b1, 4'h1, -1, 1'b0, 0);
    apply_stimulus(0, 8'd2, 32'h00, 1'b0, 4'h1, -1, 1'b0, 2);
    apply_stimulus(0, 8'd4, 32'h00, 1'b0, 4'h1, -1, 1'b0, 4);
    apply_stimulus(0, 8'd0, 32'hFF, 1'b1, 4'h1, -1, 1'b0, 5);
    apply_stimulus(0, 8'd3, 32'h77, 1'b1, 4'h0, -1, 1'b0, 0);
    apply_stimulus(0, 8'd1, 32'h55, 1'b1, 4'h1, -1, 1'b1, 0);
    apply_stimulus(0, 8'd1, 32'h00, 1'b0, 4'h1, -1, 1'b1, 0);
    apply_stimulus(0, 8'd9, 32'h12, 1'b1, 4'h1, -1, 1'b0, 0);
    apply_stimulus(0, 8'd3, 32'h66, 1'b1, 4'h1,  1, 1'b0, 0);

    // 32-bit slave, three wait states, register 2 read-only, five registers.
    apply_stimulus(1, 8'd1, 32'hAABBCCDD, 1'b1, 4'b0101, -1, 1'b0, 3);
    apply_stimulus(1, 8'd1, 32'h0,        1'b0, 4'hF,    -1, 1'b0, 6);
    apply_stimulus(1, 8'd1, 32'hDEADBEEF, 1'b1, 4'hF,     2, 1'b0, 0);
    apply_stimulus(1, 8'd0, 32'h0,        1'b0, 4'hF,     2, 1'b0, 0);
    apply_stimulus(1, 8'd2, 32'hFFFFFFFF, 1'b1, 4'hF,    -1, 1'b0, 0);
    apply_stimulus(1, 8'd4, 32'h0BADF00D, 1'b1, 4'hF,    -1, 1'b0, 0);
    apply_stimulus(1, 8'd5, 32'h0,        1'b0, 4'hF,    -1, 1'b0, 0);
    apply_stimulus(1, 8'd3, 32'hCAFEF00D, 1'b1, 4'hF,     4, 1'b0, 8);

    // Reset during the second wait cycle of a write.
    step();
    drive(1, 1'b1, 1'b1, 1'b1, 8'd1, 32'hDEADBEEF, 4'hF);
    step();
    step();
    rst = 1'b1;
    reset_model();
    pin_id = 7;
    step();
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 4'h0);
    step();
    step();

    // Random transfers, including bad addresses, aborts and back-to-back requests.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        adr  = ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(nregs_of(d)));
        dat  = $urandom;
        we   = 1'($urandom_range(1));
        sel  = 4'($urandom);
        drop = -1;
        hold = 1'b0;
        if ($urandom_range(5) == 0) drop = int'($urandom_range(wait_of(d) + 1, 1));
        else                        hold = ($urandom_range(3) == 0);
        if (n == 119) hold = 1'b0;
        apply_stimulus(d, adr, dat, we, sel, drop, hold, 0);
      end
    end

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
